// File: rtl/piso_shift_tx_if.sv
// Load/serial bundle for piso_shift_tx.
//   din        parallel word to transmit
//   load_valid din is valid
//   load_ready transmitter can accept a word (idle)
//   tick       line consumes the current sout bit this cycle
//   sout       registered serial data
//   sout_valid sout holds an unconsumed bit
//   busy       frame in progress
//   done       one-cycle pulse after the last bit is consumed
// master: word/tick source. slave: the transmitter.
interface piso_shift_tx_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             tick;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    modport master (
        output din, load_valid, tick,
        input  load_ready, sout, sout_valid, busy, done
    );

    modport slave (
        input  din, load_valid, tick,
        output load_ready, sout, sout_valid, busy, done
    );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter. A WIDTH-bit word is accepted through a
// valid/ready handshake while idle and sent one bit per tick on sout.
//   clk_i   system clock, rising edge
//   rst_ni  asynchronous active-low reset
//   tx_io   piso_shift_tx_if slave modport (din/load_valid/load_ready,
//           tick/sout/sout_valid, busy, done)
// Parameters:
//   WIDTH      word width (>= 2)
//   MSB_FIRST  1: din[WIDTH-1] sent first, 0: din[0] sent first
// Build option:
//   PIPO_TX_PARITY_EN  when defined, an even-parity bit (XOR of the captured
//                      word) follows the data bits; otherwise no parity logic.
module piso_shift_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    piso_shift_tx_if.slave   tx_io
);

    localparam int unsigned    CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

`ifdef PIPO_TX_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
    typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             done_q, done_d;
`ifdef PIPO_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (tx_io.load_valid) state_d = StShift;
            end
            StShift: begin
                if (tx_io.tick && (cnt_q == LastIdx)) begin
`ifdef PIPO_TX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef PIPO_TX_PARITY_EN
            StParity: begin
                if (tx_io.tick) state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state. The shift register holds the bits still to be sent;
    // the bit on sout has already been removed from it.
    always_comb begin
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        sout_d       = sout_q;
        sout_valid_d = sout_valid_q;
        done_d       = 1'b0;
`ifdef PIPO_TX_PARITY_EN
        parity_d     = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                // Load wins over tick; tick is ignored while idle.
                if (tx_io.load_valid) begin
                    cnt_d        = '0;
                    sout_valid_d = 1'b1;
                    if (MSB_FIRST) begin
                        sout_d  = tx_io.din[WIDTH-1];
                        shreg_d = tx_io.din << 1;
                    end else begin
                        sout_d  = tx_io.din[0];
                        shreg_d = tx_io.din >> 1;
                    end
`ifdef PIPO_TX_PARITY_EN
                    parity_d = ^tx_io.din;
`endif
                end
            end
            StShift: begin
                if (tx_io.tick) begin
                    if (cnt_q == LastIdx) begin
`ifdef PIPO_TX_PARITY_EN
                        sout_d       = parity_q;
`else
                        sout_d       = 1'b0;
                        sout_valid_d = 1'b0;
                        done_d       = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                        if (MSB_FIRST) begin
                            sout_d  = shreg_q[WIDTH-1];
                            shreg_d = shreg_q << 1;
                        end else begin
                            sout_d  = shreg_q[0];
                            shreg_d = shreg_q >> 1;
                        end
                    end
                end
            end
`ifdef PIPO_TX_PARITY_EN
            StParity: begin
                if (tx_io.tick) begin
                    sout_d       = 1'b0;
                    sout_valid_d = 1'b0;
                    done_d       = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg_q      <= '0;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef PIPO_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            done_q       <= done_d;
`ifdef PIPO_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    // Outputs
    always_comb begin
        tx_io.busy       = (state_q != StIdle);
        tx_io.load_ready = (state_q == StIdle);
        tx_io.sout       = sout_q;
        tx_io.sout_valid = sout_valid_q;
        tx_io.done       = done_q;
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: an MSB-first and an LSB-first instance receive the
// same stimulus. The driver pushes each accepted word into per-lane
// scoreboards; the monitor keeps a frame-level model (idle/busy, bit index)
// and checks every cycle's outputs against it.
module tb_piso_shift_tx;

    localparam int unsigned W = 8;
`ifdef PIPO_TX_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic clk = 1'b0;
    logic rst_n;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    piso_shift_tx_if #(.WIDTH(W)) bus0 ();
    piso_shift_tx_if #(.WIDTH(W)) bus1 ();

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .tx_io  (bus0)
    );

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .tx_io  (bus1)
    );

    logic [W-1:0] wq0[$];
    logic [W-1:0] wq1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bit idx of a frame carrying word w; index W is the even-parity bit.
    function automatic logic exp_bit(input logic [W-1:0] w, input int idx, input bit msb);
        if (idx >= int'(W)) return ^w;
        return msb ? w[int'(W) - 1 - idx] : w[idx];
    endfunction

    // One clock of stimulus: drive at posedge+1, record acceptance at negedge.
    task automatic step(input logic lv, input logic [W-1:0] d, input logic tk, output bit acc);
        bus0.load_valid = lv;
        bus0.din        = d;
        bus0.tick       = tk;
        bus1.load_valid = lv;
        bus1.din        = d;
        bus1.tick       = tk;
        @(negedge clk);
        acc = lv && bus0.load_ready;
        if (acc) begin
            wq0.push_back(d);
            wq1.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " lane0 sout"},       {31'd0, bus0.sout},       0);
        chk({tag, " lane0 sout_valid"}, {31'd0, bus0.sout_valid}, 0);
        chk({tag, " lane0 busy"},       {31'd0, bus0.busy},       0);
        chk({tag, " lane0 done"},       {31'd0, bus0.done},       0);
        chk({tag, " lane0 load_ready"}, {31'd0, bus0.load_ready}, 1);
        chk({tag, " lane1 sout"},       {31'd0, bus1.sout},       0);
        chk({tag, " lane1 sout_valid"}, {31'd0, bus1.sout_valid}, 0);
        chk({tag, " lane1 done"},       {31'd0, bus1.done},       0);
        chk({tag, " lane1 load_ready"}, {31'd0, bus1.load_ready}, 1);
    endtask

    // Monitor: frame-level model per lane
    bit           m_busy[2];
    bit           m_done[2];
    bit           m_have[2];
    int           m_idx[2];
    logic [W-1:0] m_word[2];
    logic [1:0]   s_so, s_sv, s_bz, s_dn, s_lr, s_lv, s_tk;

    initial begin
        forever begin
            @(negedge clk);
            s_so = {bus1.sout, bus0.sout};
            s_sv = {bus1.sout_valid, bus0.sout_valid};
            s_bz = {bus1.busy, bus0.busy};
            s_dn = {bus1.done, bus0.done};
            s_lr = {bus1.load_ready, bus0.load_ready};
            s_lv = {bus1.load_valid, bus0.load_valid};
            s_tk = {bus1.tick, bus0.tick};
            for (int l = 0; l < 2; l++) begin
                if (!mon_en) begin
                    m_busy[l] = 1'b0;
                    m_done[l] = 1'b0;
                    m_have[l] = 1'b0;
                    m_idx[l]  = 0;
                end else begin
                    chk($sformatf("lane%0d busy", l),       {31'd0, s_bz[l]}, {31'd0, m_busy[l]});
                    chk($sformatf("lane%0d sout_valid", l), {31'd0, s_sv[l]}, {31'd0, m_busy[l]});
                    chk($sformatf("lane%0d load_ready", l), {31'd0, s_lr[l]}, {31'd0, !m_busy[l]});
                    chk($sformatf("lane%0d done", l),       {31'd0, s_dn[l]}, {31'd0, m_done[l]});
                    if (m_busy[l]) begin
                        if (!m_have[l]) begin
                            if ((l == 0 ? wq0.size() : wq1.size()) == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL lane%0d scoreboard: got empty queue expected a word", l);
                            end else begin
                                if (l == 0) m_word[l] = wq0.pop_front();
                                else        m_word[l] = wq1.pop_front();
                            end
                            m_have[l] = 1'b1;
                        end
                        chk($sformatf("lane%0d sout word %0h bit %0d", l, m_word[l], m_idx[l]),
                            {31'd0, s_so[l]}, {31'd0, exp_bit(m_word[l], m_idx[l], l == 0)});
                    end else begin
                        chk($sformatf("lane%0d idle sout", l), {31'd0, s_so[l]}, 0);
                    end
                    // Advance the model to the state after the coming edge.
                    m_done[l] = 1'b0;
                    if (m_busy[l]) begin
                        if (s_tk[l]) begin
                            m_idx[l]++;
                            if (m_idx[l] == FL) begin
                                m_busy[l] = 1'b0;
                                m_done[l] = 1'b1;
                            end
                        end
                    end else if (s_lv[l]) begin
                        m_busy[l] = 1'b1;
                        m_idx[l]  = 0;
                        m_have[l] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        bit acc;
        bit got;
        rst_n = 1'b0;
        bus0.load_valid = 1'b0; bus0.din = '0; bus0.tick = 1'b0;
        bus1.load_valid = 1'b0; bus1.din = '0; bus1.tick = 1'b0;
        #7;
        check_reset_outputs("reset");
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // A5, tick every cycle
        step(1'b1, 8'hA5, 1'b0, acc);
        for (int i = 0; i < FL; i++) step(1'b0, '0, 1'b1, acc);
        repeat (2) step(1'b0, '0, 1'b0, acc);

        // 01, tick only every third cycle
        step(1'b1, 8'h01, 1'b0, acc);
        for (int i = 0; i < 3 * FL; i++) step(1'b0, '0, (i % 3) == 2, acc);
        repeat (2) step(1'b0, '0, 1'b0, acc);

        // F0 then 0F held valid during the frame
        step(1'b1, 8'hF0, 1'b1, acc);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step(1'b1, 8'h0F, 1'b1, acc);
            got = acc;
        end
        chk("held load accepted", {31'd0, got}, 1);
        for (int i = 0; i < FL + 2; i++) step(1'b0, '0, 1'b1, acc);

        // C3, three ticks, then asynchronous reset mid-cycle
        step(1'b1, 8'hC3, 1'b0, acc);
        repeat (3) step(1'b0, '0, 1'b1, acc);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_reset_outputs("async reset");
        wq0.delete();
        wq1.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        step(1'b1, 8'h3C, 1'b0, acc);
        for (int i = 0; i < FL + 1; i++) step(1'b0, '0, 1'b1, acc);

        // Tick in idle, then load with tick high at the load edge
        repeat (10) step(1'b0, '0, 1'b1, acc);
        step(1'b1, 8'h80, 1'b1, acc);
        for (int i = 0; i < FL + 1; i++) step(1'b0, '0, 1'b1, acc);

`ifdef PIPO_TX_PARITY_EN
        step(1'b1, 8'h07, 1'b0, acc);
        for (int i = 0; i < FL + 1; i++) step(1'b0, '0, 1'b1, acc);
`endif

        // Random traffic, including loads in the same cycle as done
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 3) == 0, W'($urandom()), $urandom_range(0, 9) < 6, acc);
        end
        for (int i = 0; i < 2 * FL + 4; i++) step(1'b0, '0, 1'b1, acc);

        chk("lane0 words left", wq0.size(), 0);
        chk("lane1 words left", wq1.size(), 0);
        chk("final lane0 busy", {31'd0, bus0.busy}, 0);
        chk("final lane1 busy", {31'd0, bus1.busy}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
